// File: rtl/gf_muldiv_ctrl.sv
// rtl/gf_muldiv_ctrl.sv - sequenced GF(2^8) multiply/divide over a shared exp/log table
module gf_muldiv_ctrl #(
  parameter int M    = 255,
  parameter int SIZE = $clog2(M)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] result,
  output logic            div_by_zero,
  output logic [SIZE-1:0] lut_index,
  input  logic [SIZE-1:0] lut_exp,
  input  logic [SIZE-1:0] lut_log
);

  localparam logic [SIZE:0] M_W = (SIZE+1)'(M);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOG_A = 3'd1,
    LOG_B = 3'd2,
    EXP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic            op_q, op_d;
  logic [SIZE-1:0] la_q, la_d;
  logic [SIZE-1:0] e_q, e_d;
  logic [SIZE-1:0] result_q, result_d;
  logic            dbz_q, dbz_d;

  logic [SIZE:0]   sum_raw, sum_mod;
  logic [SIZE:0]   diff_raw, diff_mod;

  // Log-domain add/subtract reduced into 0..M-1; the wide sum never reaches 2*M.
  always_comb begin
    sum_raw  = {1'b0, la_q} + {1'b0, lut_log};
    sum_mod  = sum_raw;
    if (sum_raw >= M_W) begin
      sum_mod = sum_raw - M_W;
    end
    diff_raw = {1'b0, la_q} - {1'b0, lut_log};
    diff_mod = diff_raw;
    if (la_q < lut_log) begin
      diff_mod = diff_raw + M_W;
    end
  end

  // Next-state, table index decode and handshake outputs, all from registered state.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    la_d      = la_q;
    e_d       = e_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    lut_index = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d  = a;
          b_d  = b;
          op_d = op;
          if ((a == '0) || (b == '0)) begin
            // Zero operand: answer is known without touching the table.
            result_d = '0;
            dbz_d    = op & (b == '0);
            state_d  = DONE;
          end else begin
            state_d = LOG_A;
          end
        end
      end
      LOG_A: begin
        lut_index = a_q;
        la_d      = lut_log;
        state_d   = LOG_B;
      end
      LOG_B: begin
        lut_index = b_q;
        e_d       = op_q ? diff_mod[SIZE-1:0] : sum_mod[SIZE-1:0];
        state_d   = EXP;
      end
      EXP: begin
        lut_index = e_q;
        result_d  = lut_exp;
        dbz_d     = 1'b0;
        state_d   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      la_q     <= '0;
      e_q      <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      la_q     <= la_d;
      e_q      <= e_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf_muldiv_ctrl.sv
// tb/tb_gf_muldiv_ctrl.sv - randomized and directed checks of gf_muldiv_ctrl against a GF(2^8) model
module tb_gf_muldiv_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       div_by_zero;
  logic [7:0] lut_index;
  logic [7:0] lut_exp;
  logic [7:0] lut_log;

  int checks;
  int failures;

  logic [7:0] exp_t [0:255];
  logic [7:0] log_t [0:255];

  gf_muldiv_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_by_zero(div_by_zero),
    .lut_index  (lut_index),
    .lut_exp    (lut_exp),
    .lut_log    (lut_log)
  );

  assign lut_exp = exp_t[lut_index];
  assign lut_log = log_t[lut_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Carry-less multiply reduced by x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ (16'(x) << i);
    end
    for (int i = 15; i >= 8; i--) begin
      if (p[i]) p = p ^ (16'h011d << (i - 8));
    end
    return p[7:0];
  endfunction

  // Division by exhaustive search for the quotient.
  function automatic logic [7:0] gf_div(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] q;
    q = '0;
    for (int i = 1; i < 256; i++) begin
      if (gf_mul(y, 8'(i)) == x) q = 8'(i);
    end
    return q;
  endfunction

  task automatic run_txn(input logic t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                         input int hold, input logic [7:0] want, input bit use_want);
    logic [7:0] exp_r;
    logic       exp_dbz;
    logic [7:0] exp_idx [4];
    int         exp_lat;
    int         lat;
    bit         zero;
    zero = (t_a == 8'h00) || (t_b == 8'h00);
    if (zero) begin
      exp_r   = 8'h00;
      exp_dbz = t_op && (t_b == 8'h00);
      exp_lat = 1;
    end else begin
      exp_r   = t_op ? gf_div(t_a, t_b) : gf_mul(t_a, t_b);
      exp_dbz = 1'b0;
      exp_lat = 4;
      exp_idx[0] = t_a;
      exp_idx[1] = t_b;
      exp_idx[2] = t_op ? 8'((int'(log_t[t_a]) - int'(log_t[t_b]) + 255) % 255)
                        : 8'((int'(log_t[t_a]) + int'(log_t[t_b])) % 255);
      exp_idx[3] = 8'h00;
    end
    if (use_want) check("model_vs_plan", {24'h0, exp_r}, {24'h0, want});

    @(negedge clk);
    check("in_ready_idle", {31'h0, in_ready}, 32'h1);
    check("lut_index_idle", {24'h0, lut_index}, 32'h0);
    in_valid  = 1'b1;
    op        = t_op;
    a         = t_a;
    b         = t_b;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    op       = 1'($urandom);
    a        = 8'($urandom);
    b        = 8'($urandom);
    lat      = 1;
    while (1) begin
      if (zero) check("lut_index_zero", {24'h0, lut_index}, 32'h0);
      else if (lat <= 4) check($sformatf("lut_index_%0d", lat), {24'h0, lut_index}, {24'h0, exp_idx[lat-1]});
      if (out_valid === 1'b1) break;
      if (lat >= 12) begin
        check("out_valid_timeout", 32'h0, 32'h1);
        break;
      end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("result", {24'h0, result}, {24'h0, exp_r});
    check("div_by_zero", {31'h0, div_by_zero}, {31'h0, exp_dbz});
    check("in_ready_busy", {31'h0, in_ready}, 32'h0);

    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = 8'($urandom);
      b        = 8'($urandom);
      @(negedge clk);
      check("hold_valid", {31'h0, out_valid}, 32'h1);
      check("hold_result", {24'h0, result}, {24'h0, exp_r});
      check("hold_dbz", {31'h0, div_by_zero}, {31'h0, exp_dbz});
      check("hold_in_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_out_valid", {31'h0, out_valid}, 32'h0);
    check("handoff_in_ready", {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] ra, rb;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b0;

    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = 8'(i);
      x = gf_mul(x, 8'h02);
    end
    exp_t[255] = 8'h00;
    log_t[0]   = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_result", {24'h0, result}, 32'h0);
    check("rst_dbz", {31'h0, div_by_zero}, 32'h0);
    check("rst_lut_index", {24'h0, lut_index}, 32'h0);
    rst_n = 1'b1;

    run_txn(1'b0, 8'h02, 8'h03, 0, 8'h06, 1'b1);
    run_txn(1'b0, 8'h80, 8'h02, 1, 8'h1D, 1'b1);
    run_txn(1'b0, 8'hFF, 8'hFF, 0, 8'hE2, 1'b1);
    run_txn(1'b1, 8'h01, 8'h02, 0, 8'h8E, 1'b1);
    run_txn(1'b1, 8'h06, 8'h03, 2, 8'h02, 1'b1);
    run_txn(1'b1, 8'h05, 8'h00, 0, 8'h00, 1'b1);
    run_txn(1'b0, 8'h00, 8'h37, 0, 8'h00, 1'b1);
    run_txn(1'b1, 8'h5A, 8'h5A, 0, 8'h01, 1'b1);
    run_txn(1'b0, 8'h02, 8'h8E, 0, 8'h01, 1'b1);
    run_txn(1'b1, 8'hFF, 8'hFF, 0, 8'h01, 1'b1);
    run_txn(1'b0, 8'h11, 8'h22, 10, 8'h00, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_txn(1'($urandom), ra, rb, int'($urandom_range(0, 3)), 8'h00, 1'b0);
    end

    @(negedge clk);
    in_valid = 1'b1;
    op       = 1'b0;
    a        = 8'h33;
    b        = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_lut_index_b", {24'h0, lut_index}, 32'h44);
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("async_rst_lut_index", {24'h0, lut_index}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", {31'h0, out_valid}, 32'h0);
      check("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
